note_sequencer: RTL

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_pkg.sv | 29 ++
 rtl/note_fifo.sv | 58 +++++
 rtl/note_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared types for the note sequencer: FSM states, rest codes and the FIFO record.
// Build option NOTE_SEQ_GAP_EN adds the GAP state between notes.
package note_pkg;

    localparam logic [4:0] REST_LO = 5'd30;
    localparam logic [4:0] REST_HI = 5'd31;
    localparam int         EVT_W   = 13;

    typedef struct packed {
        logic [4:0] note;
        logic [7:0] dur;
    } note_evt_t;

`ifdef NOTE_SEQ_GAP_EN
    typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_t;
`else
    typedef enum logic [1:0] {IDLE, PLAY} seq_state_t;
`endif

    function automatic logic is_rest(input logic [4:0] n);
        return (n == REST_LO) || (n == REST_HI);
    endfunction

    // A zero duration still plays for one tick.
    function automatic logic [7:0] eff_dur(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; clear beats push and pop.
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == FULL_CNT);
    assign empty   = (fill == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued {note, dur} events as one-hot pitch codes, one tick = TICK_DIV clocks.
// Build option NOTE_SEQ_GAP_EN inserts GAP_TICKS silent ticks after every note.
module note_sequencer
    import note_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int TICK_DIV  = 2500000,
    parameter int GAP_TICKS = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [4:0]               in_note,
    input  logic [7:0]               in_dur,
    output logic                     in_ready,
    input  logic                     play_en,
    input  logic                     flush,
    output logic [31:0]              note_out,
    output logic                     note_active,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TICK_DIV < 1 || GAP_TICKS < 1)
    begin : g_bad_cfg
        $error("note_sequencer: unsupported DEPTH/TICK_DIV/GAP_TICKS");
    end

    seq_state_t      state, state_n;
    note_evt_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic [4:0]      cur_note;
    logic [TW-1:0]   tick_cnt;
    logic [7:0]      dur_cnt;
    logic            tick_last;
    logic            dur_last;
    logic [31:0]     note_out_n;
    logic            active_n;

    assign in_ready  = !fifo_full && !flush;
    assign tick_last = (tick_cnt == TICK_LAST);
    assign dur_last  = (dur_cnt == 8'd1);

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .clear (flush),
        .wdata ({in_note, in_dur}),
        .rdata (head),
        .fill  (fill),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef NOTE_SEQ_GAP_EN
    localparam int            GW       = $clog2(GAP_TICKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    logic [GW-1:0] gap_cnt;
    logic          gap_last;

    assign gap_last = (gap_cnt == GAP_LAST);
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        note_out_n = '0;
        active_n   = 1'b0;
        if (!flush && play_en && state == PLAY && !is_rest(cur_note)) begin
            note_out_n = 32'd1 << cur_note;
            active_n   = 1'b1;
        end
        if (flush) begin
            state_n = IDLE;
        end else if (play_en) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_last && dur_last) begin
`ifdef NOTE_SEQ_GAP_EN
                        state_n = GAP;
`else
                        // Chain straight into the next note so there is no silent cycle.
                        if (!fifo_empty) pop = 1'b1;
                        else             state_n = IDLE;
`endif
                    end
                end
`ifdef NOTE_SEQ_GAP_EN
                GAP: begin
                    if (tick_last && gap_last) begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_n = PLAY;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // Counters only move while play_en is high, so a pause resumes with the remaining count.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cur_note    <= '0;
            tick_cnt    <= '0;
            dur_cnt     <= '0;
            note_out    <= '0;
            note_active <= 1'b0;
`ifdef NOTE_SEQ_GAP_EN
            gap_cnt     <= '0;
`endif
        end else begin
            note_out    <= note_out_n;
            note_active <= active_n;
            if (flush) begin
                cur_note <= '0;
                tick_cnt <= '0;
                dur_cnt  <= '0;
            end else if (play_en) begin
                if (pop) begin
                    cur_note <= head.note;
                    dur_cnt  <= eff_dur(head.dur);
                    tick_cnt <= '0;
                end else if (state != IDLE) begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        if (state == PLAY) begin
                            dur_cnt <= dur_cnt - 1'b1;
`ifdef NOTE_SEQ_GAP_EN
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
`endif
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
